button_event_arbiter: RTL and testbench

Collects press events from N debounced button lines (each driven by a debouncer instance) and serialises them into a single event stream with a valid/ready handshake. Rising edges are latched as per-line pending flags, a round-robin arbiter grants one pending line at a time into a one-entry output register, and lost events are reported through sticky overflow flags. The block sits between the debouncer bank and the command/control FSM that consumes button actions.

---
 rtl/button_event_arbiter.sv | 141 ++++++++++++++
 tb/tb_button_event_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// button_event_arbiter
// Latches rising edges from N debounced button lines as pending flags and
// serialises them, round-robin, into a one-entry event register with a
// valid/ready output. Lost events (a new edge on a line that still has an
// ungranted pending flag) set sticky per-line ovf bits.
//
// Handshake: evt_valid/evt_id/evt_rel describe the event in the slot; the
// event is consumed on a rising clk edge where evt_valid && evt_ready. While
// evt_valid && !evt_ready the payload holds stable and nothing is granted.
//
// Optional feature: define BUTTON_EVT_RELEASE_EN to also report falling
// edges as release events (evt_rel=1). Without it evt_rel is tied to 0.
module button_event_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   btn,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  output logic           evt_rel,
  input  logic           evt_ready,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   ovf,
  input  logic           ovf_clr
);

`ifdef BUTTON_EVT_RELEASE_EN
  localparam int R = 2 * N;
`else
  localparam int R = N;
`endif
  localparam int PW = $clog2(R);

  logic [N-1:0]   btn_q;
  logic [N-1:0]   rise;
  logic [N-1:0]   press_gnt;
  logic [N-1:0]   press_lost;
  logic [N-1:0]   rel_lost;
  logic [R-1:0]   req;
  logic [R-1:0]   gnt_vec;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  gnt_idx;
  logic [PW-1:0]  rr_next;
  logic [IDW-1:0] gnt_id;
  logic           gnt_rel;
  logic           gnt_any;
  logic           slot_free;
  logic           grant;

  assign rise      = btn & ~btn_q;
  assign slot_free = !evt_valid || evt_ready;
  assign grant     = slot_free && gnt_any;
  assign press_gnt = gnt_vec[N-1:0];
  // A rise on a line whose flag is still set and not being granted is lost.
  assign press_lost = rise & pending & ~press_gnt;

`ifdef BUTTON_EVT_RELEASE_EN
  logic [N-1:0] fall;
  logic [N-1:0] rel_pending;
  logic [N-1:0] rel_gnt;

  assign fall     = ~btn & btn_q;
  assign rel_gnt  = gnt_vec[R-1:N];
  assign rel_lost = fall & rel_pending & ~rel_gnt;
  // Request order: press0..pressN-1, rel0..relN-1.
  assign req      = {rel_pending, pending};

  // Release flags follow the same set/clear rules as the press flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rel_pending <= '0;
    end else begin
      rel_pending <= (rel_pending & ~rel_gnt) | fall;
    end
  end

  // Release indication travels with the granted event.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_rel <= 1'b0;
    end else if (grant) begin
      evt_rel <= gnt_rel;
    end
  end
`else
  assign rel_lost = '0;
  assign req      = pending;
  assign evt_rel  = 1'b0;
`endif

  // Round-robin scan: first request at or above rr_ptr, wrapping modulo R.
  always_comb begin : scan
    int idx;
    int gi;
    idx     = 0;
    gi      = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    for (int k = 0; k < R; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= R) idx = idx - R;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (grant) gnt_vec[gnt_idx] = 1'b1;
    rr_next = (gnt_idx == PW'(R - 1)) ? '0 : gnt_idx + PW'(1);
    gi      = int'(gnt_idx);
    gnt_rel = (gi >= N);
    gnt_id  = IDW'((gi >= N) ? gi - N : gi);
  end

  // Edge capture, pending/overflow bookkeeping and the one-entry event slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q     <= '0;
      pending   <= '0;
      ovf       <= '0;
      rr_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
    end else begin
      btn_q   <= btn;
      pending <= (pending & ~press_gnt) | rise;
      // A new loss in the same cycle as ovf_clr survives the clear.
      ovf     <= (ovf_clr ? '0 : ovf) | press_lost | rel_lost;
      if (slot_free) begin
        evt_valid <= gnt_any;
        if (gnt_any) begin
          evt_id <= gnt_id;
          rr_ptr <= rr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Testbench for button_event_arbiter: directed scenarios, expected events
// queued as stimulus is applied and compared as the consumer accepts them.
module tb_button_event_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   btn;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_rel;
  logic           evt_ready;
  logic [N-1:0]   pending;
  logic [N-1:0]   ovf;
  logic           ovf_clr;

  logic [IDW:0] exp_q[$];   // {rel, id}
  int vectors     = 0;
  int miscompares = 0;
  bit chk_rel     = 1'b0;

  button_event_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_rel   (evt_rel),
    .evt_ready (evt_ready),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; btn = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic push_evt(input logic rel, input int id);
    exp_q.push_back({rel, IDW'(id)});
  endtask

  // Scoreboard: each accepted event is compared with the oldest expectation.
  always @(negedge clk) begin : monitor
    logic [IDW:0] e;
    if (!rst && evt_valid && evt_ready) begin
`ifdef BUTTON_EVT_RELEASE_EN
      if (!evt_rel || chk_rel) begin
`else
      begin
`endif
        if (exp_q.size() == 0) begin
          check("evt_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("evt", {29'd0, evt_rel, evt_id}, {29'd0, e});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; btn = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    at_neg();
    check("rst_valid", evt_valid, 0);
    check("rst_id", evt_id, 0);
    check("rst_rel", evt_rel, 0);
    check("rst_pending", pending, 0);
    check("rst_ovf", ovf, 0);

    // Single press on line 2: valid two edges after the rise, for one cycle.
    do_reset();
    btn = 4'b0100; evt_ready = 1'b1; push_evt(0, 2);
    at_neg(); check("s1_valid_e0", evt_valid, 0);
    at_neg(); check("s1_valid_e1", evt_valid, 0); check("s1_pend_e1", pending, 4'b0100);
    at_neg(); check("s1_valid_e2", evt_valid, 1); check("s1_id_e2", evt_id, 2);
    check("s1_pend_e2", pending, 0);
    at_neg(); check("s1_valid_e3", evt_valid, 0);

    // Simultaneous rises 1011 drain as 0, 1, 3 back-to-back.
    do_reset();
    btn = 4'b1011; evt_ready = 1'b1; push_evt(0, 0); push_evt(0, 1); push_evt(0, 3);
    at_neg(); at_neg(); check("s2_pend", pending, 4'b1011);
    at_neg(); check("s2_id0", evt_id, 0); check("s2_v0", evt_valid, 1);
    at_neg(); check("s2_id1", evt_id, 1); check("s2_v1", evt_valid, 1);
    at_neg(); check("s2_id3", evt_id, 3); check("s2_v3", evt_valid, 1);
    check("s2_pend_done", pending, 0);
    at_neg(); check("s2_v_end", evt_valid, 0);
    // Pointer wrapped to 0: lines 1 and 2 come out as 1 then 2.
    tick(); btn = 4'b0000;
    tick(3); btn = 4'b0110; push_evt(0, 1); push_evt(0, 2);
    tick(6);

    // Backpressure, overflow and ovf_clr.
    do_reset();
    btn = 4'b0010; evt_ready = 1'b0; push_evt(0, 1);
    tick(3);
    repeat (3) begin
      at_neg(); check("s3_hold_valid", evt_valid, 1); check("s3_hold_id", evt_id, 1);
    end
    tick(); btn = 4'b0000;
    tick(); btn = 4'b0010;
    tick(); btn = 4'b0000;
    tick(); btn = 4'b0010;
    tick(); at_neg();
    check("s3_ovf", ovf, 4'b0010); check("s3_pend", pending, 4'b0010);
    check("s3_still_id", evt_id, 1);
    tick(); evt_ready = 1'b1; push_evt(0, 1);
    tick(6); at_neg();
    check("s3_drained", evt_valid, 0); check("s3_ovf_sticky", ovf, 4'b0010);
    check("s3_pend_clr", pending, 0);
    tick(); ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    at_neg(); check("s3_ovf_clr", ovf, 0);
    // Overflow coinciding with ovf_clr wins.
    tick(); evt_ready = 1'b0; btn = 4'b0011;
    tick(3); btn = 4'b0010;
    tick(); btn = 4'b0011;
    tick(); btn = 4'b0010;
    tick(); btn = 4'b0011; ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    at_neg(); check("s3_ovf_race", ovf, 4'b0001);
    tick(); evt_ready = 1'b1; push_evt(0, 0); push_evt(0, 0);
    tick(6);

    // Rise on line 3 in the same cycle it is granted.
    do_reset();
    btn = 4'b0001;
    tick(3); btn = 4'b1001;
    tick(); btn = 4'b0001;
    tick(); btn = 4'b1001; evt_ready = 1'b1;
    push_evt(0, 0); push_evt(0, 3); push_evt(0, 3);
    tick(); at_neg();
    check("s4_id", evt_id, 3); check("s4_valid", evt_valid, 1);
    check("s4_pend3", pending, 4'b1000); check("s4_ovf", ovf, 0);
    tick(5); at_neg();
    check("s4_pend_end", pending, 0); check("s4_ovf_end", ovf, 0);
    check("s4_valid_end", evt_valid, 0);

    // Reset mid-operation discards slot and pending flags.
    do_reset();
    btn = 4'b0001;
    tick(3); btn = 4'b1011;
    tick(); at_neg();
    check("s5_valid_pre", evt_valid, 1); check("s5_pend_pre", pending, 4'b1010);
    tick(); rst = 1'b1; btn = 4'b0000;
    tick(); rst = 1'b0;
    at_neg();
    check("s5_valid_post", evt_valid, 0); check("s5_pend_post", pending, 0);
    check("s5_ovf_post", ovf, 0);
    tick(); evt_ready = 1'b1;
    tick(5); at_neg(); check("s5_idle", evt_valid, 0);
    // A button held through reset yields exactly one more press.
    tick(); btn = 4'b0100; push_evt(0, 2);
    tick(5); rst = 1'b1;
    tick(2); rst = 1'b0; push_evt(0, 2);
    tick(6);

    // Press then release on line 0.
    do_reset();
    evt_ready = 1'b1; chk_rel = 1'b1; btn = 4'b0001; push_evt(0, 0);
    tick(4); btn = 4'b0000;
`ifdef BUTTON_EVT_RELEASE_EN
    push_evt(1, 0);
`endif
    tick(5); chk_rel = 1'b0;

    tick(3);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
